// File: rtl/pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// pipe_stage_buffer
//   Elastic buffer between two CPU pipeline stages. It holds up to DEPTH
//   payloads in a circular store and hands them on with valid/ready
//   handshakes on both sides. A flush input discards everything held, which
//   is used on branch/jump redirects. With PASSTHRU=1 an empty buffer
//   forwards its input to its output in the same cycle. With PASSTHRU=0 a
//   payload always spends at least one cycle in storage.
//
// Parameters
//   WIDTH    payload width in bits
//   DEPTH    number of storage entries (1..16, need not be a power of two)
//   PASSTHRU 1 = same-cycle forwarding when empty, 0 = registered only
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   flush      synchronous discard of all held entries
//   in_valid   producer offers in_data
//   in_ready   buffer accepts in_data this cycle
//   in_data    payload from the upstream stage
//   out_valid  out_data holds a valid entry
//   out_ready  consumer takes out_data this cycle
//   out_data   oldest held entry, or the bypassed input
//   count      number of held entries
// ---------------------------------------------------------------------------
module pipe_stage_buffer #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int PASSTHRU = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam bit PT = (PASSTHRU != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_has_data;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_has_data = (r_count != '0);

  // in_ready looks only at occupancy and flush, never at out_ready, so a
  // full buffer does not accept even when it is being drained this cycle.
  assign in_ready  = (r_count < CW'(DEPTH)) && !flush;
  assign out_valid = !flush && (w_has_data || (PT && in_valid));

  // Forwarded payload is consumed directly and never written to storage.
  assign w_bypass = PT && !w_has_data && in_valid && out_ready && !flush;
  assign w_push   = in_valid && in_ready && !w_bypass;
  assign w_pop    = out_valid && out_ready && w_has_data;

  assign out_data = (w_has_data || !PT) ? r_mem[r_rd_ptr] : in_data;
  assign count    = r_count;

  // Storage is not reset; its contents are only observed when count > 0.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_mem[gi] <= in_data;
        end
      end
    end
  endgenerate

  // Flush gates in_ready and out_valid, so push/pop are already suppressed;
  // the explicit branch additionally returns both pointers to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buffer
//   Three buffers share clk/rst:
//     unit 0: DEPTH=2, PASSTHRU=0
//     unit 1: DEPTH=2, PASSTHRU=1
//     unit 2: DEPTH=3, PASSTHRU=0
//   Each unit has a queue-based reference model. Directed scenarios are
//   followed by random traffic. Inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buffer;

  logic        clk;
  logic        rst;
  logic        flush_s  [3];
  logic        in_vld   [3];
  logic        in_rdy   [3];
  logic [31:0] in_dat   [3];
  logic        out_vld  [3];
  logic        out_rdy  [3];
  logic [31:0] out_dat  [3];
  logic [1:0]  cnt      [3];

  int          depth_of [3];
  bit          pt_of    [3];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  int vectors;
  int miscompares;

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(2), .PASSTHRU(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush_s[0]),
    .in_valid(in_vld[0]), .in_ready(in_rdy[0]), .in_data(in_dat[0]),
    .out_valid(out_vld[0]), .out_ready(out_rdy[0]), .out_data(out_dat[0]),
    .count(cnt[0]));

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(2), .PASSTHRU(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush_s[1]),
    .in_valid(in_vld[1]), .in_ready(in_rdy[1]), .in_data(in_dat[1]),
    .out_valid(out_vld[1]), .out_ready(out_rdy[1]), .out_data(out_dat[1]),
    .count(cnt[1]));

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(3), .PASSTHRU(0)) u2 (
    .clk(clk), .rst(rst), .flush(flush_s[2]),
    .in_valid(in_vld[2]), .in_ready(in_rdy[2]), .in_data(in_dat[2]),
    .out_valid(out_vld[2]), .out_ready(out_rdy[2]), .out_data(out_dat[2]),
    .count(cnt[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s unit%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] q_head(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_clear(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic q_pop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input logic [31:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic idle_all();
    for (int j = 0; j < 3; j++) begin
      in_vld[j]  = 1'b0;
      in_dat[j]  = '0;
      out_rdy[j] = 1'b0;
      flush_s[j] = 1'b0;
    end
  endtask

  // One clock cycle on unit k (others idle), called just after a falling
  // edge. Checks the combinational outputs and the held count, then lets
  // the model and the DUT advance through the rising edge.
  task automatic step(input int k, input bit v, input logic [31:0] d,
                      input bit r, input bit f);
    int  n;
    bit  e_rdy, e_ov, byp, do_pop, do_push;
    idle_all();
    in_vld[k]  = v;
    in_dat[k]  = d;
    out_rdy[k] = r;
    flush_s[k] = f;
    #1;
    n      = q_size(k);
    e_rdy  = (n < depth_of[k]) && !f;
    e_ov   = !f && (n > 0 || (pt_of[k] && v));
    chk("count",     k, 32'(cnt[k]),     32'(n));
    chk("in_ready",  k, 32'(in_rdy[k]),  32'(e_rdy));
    chk("out_valid", k, 32'(out_vld[k]), 32'(e_ov));
    if (e_ov) chk("out_data", k, out_dat[k], (n > 0) ? q_head(k) : d);
    if (f) begin
      q_clear(k);
    end else begin
      byp     = pt_of[k] && n == 0 && v && r;
      do_pop  = r && n > 0;
      do_push = v && n < depth_of[k] && !byp;
      if (do_pop)  q_pop(k);
      if (do_push) q_push(k, d);
    end
    @(negedge clk);
  endtask

  logic [31:0] vals [5];
  int          idx;
  bit          v_r, r_r;

  initial begin
    vectors     = 0;
    miscompares = 0;
    depth_of    = '{2, 2, 3};
    pt_of       = '{1'b0, 1'b1, 1'b0};
    idle_all();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_count", k, 32'(cnt[k]), 32'd0);
      chk("rst_out_valid", k, 32'(out_vld[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Fill to full with the consumer stalled, overflow attempt, then drain.
    step(0, 1, 32'hA1, 0, 0);
    step(0, 1, 32'hA2, 0, 0);
    step(0, 1, 32'hA3, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Streaming with wrap-around.
    for (int i = 1; i <= 8; i++) step(0, 1, 32'(i), 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Same-cycle bypass, then a stalled push that lands in storage.
    step(1, 1, 32'h55, 1, 0);
    step(1, 1, 32'h55, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);

    // Flush wins over a simultaneous push and pop.
    step(0, 1, 32'hB1, 0, 0);
    step(0, 1, 32'hB2, 0, 0);
    step(0, 1, 32'hB3, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'hB4, 0, 0);
    step(1, 1, 32'hB5, 1, 1);
    step(1, 0, 0, 1, 0);

    // Depth 3: five values with random consumer stalls.
    for (int i = 0; i < 5; i++) vals[i] = 32'hD0 + 32'(i);
    idx = 0;
    for (int c = 0; c < 80; c++) begin
      if (idx >= 5 && q_size(2) == 0) break;
      v_r = (idx < 5) && ($urandom_range(0, 3) != 0);
      r_r = ($urandom_range(0, 1) == 1);
      if (v_r && q_size(2) < 3) begin
        step(2, 1, vals[idx], r_r, 0);
        idx++;
      end else begin
        step(2, 0, 0, r_r, 0);
      end
    end
    chk("dep3_all_pushed", 2, 32'(idx), 32'd5);
    step(2, 0, 0, 0, 0);

    // Random traffic on every unit, occasional flush.
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 150; c++) begin
        step(k, $urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end
      step(k, 0, 0, 1, 0);
      step(k, 0, 0, 1, 0);
      step(k, 0, 0, 1, 0);
      step(k, 0, 0, 0, 0);
    end

    // Asynchronous reset between edges with the buffer full.
    step(0, 1, 32'hE1, 0, 0);
    step(0, 1, 32'hE2, 0, 0);
    idle_all();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 0, 32'(cnt[0]), 32'd0);
    chk("async_rst_out_valid", 0, 32'(out_vld[0]), 32'd0);
    for (int k = 0; k < 3; k++) q_clear(k);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 32'hC0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
